// File: rtl/vga_timing_pkg.sv
// 640x480@60 timing defaults shared by the VGA controller and receiver,
// plus the receiver FSM state encodings.
package vga_timing_pkg;

  localparam int unsigned VgaHVisible   = 640;
  localparam int unsigned VgaHFront     = 16;
  localparam int unsigned VgaHSync      = 96;
  localparam int unsigned VgaHBack      = 48;
  localparam int unsigned VgaVVisible   = 480;
  localparam int unsigned VgaVFront     = 10;
  localparam int unsigned VgaVSync      = 2;
  localparam int unsigned VgaVBack      = 33;
  localparam int unsigned VgaLockFrames = 2;

  localparam logic [1:0] StSearch  = 2'd0;
  localparam logic [1:0] StMeasure = 2'd1;
  localparam logic [1:0] StLocked  = 2'd2;

  function automatic int unsigned vga_total(input int unsigned visible, input int unsigned front,
                                            input int unsigned sync, input int unsigned back);
    return visible + front + sync + back;
  endfunction

endpackage

// File: rtl/vga_sync_edge.sv
// Registers one sync input and flags the cycle its active level begins.
module vga_sync_edge #(
  parameter bit ActiveLow = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sync_i,
  output logic edge_o
);

  logic sync_q, sync_d;
  logic prev_q, prev_d;
  logic active;

  always_comb begin
    sync_d = sync_i;
    active = ActiveLow ? !sync_q : sync_q;
    prev_d = active;
    edge_o = active && !prev_q;
  end

  // Reset to the inactive level so leaving reset never fakes an edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= ActiveLow;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

endmodule

// File: rtl/vga_sync_receiver.sv
// VGA sink: recovers line/frame timing from h_sync/v_sync, validates it against
// the configured mode and emits registered row/col/visible/rgb.
module vga_sync_receiver
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_VISIBLE       = VgaHVisible,
  parameter int unsigned H_FRONT         = VgaHFront,
  parameter int unsigned H_SYNC          = VgaHSync,
  parameter int unsigned H_BACK          = VgaHBack,
  parameter int unsigned V_VISIBLE       = VgaVVisible,
  parameter int unsigned V_FRONT         = VgaVFront,
  parameter int unsigned V_SYNC          = VgaVSync,
  parameter int unsigned V_BACK          = VgaVBack,
  parameter bit          SYNC_ACTIVE_LOW = 1'b1,
  parameter int unsigned LOCK_FRAMES     = VgaLockFrames
) (
  input  logic       pixel_clk,
  input  logic       reset_n,
  input  logic       h_sync,
  input  logic       v_sync,
  input  logic       R,
  input  logic       G,
  input  logic       B,
  output logic       locked,
  output logic       visible,
  output logic [9:0] row,
  output logic [9:0] col,
  output logic [2:0] rgb,
  output logic       line_start,
  output logic       frame_start
);

  localparam int unsigned HTotal  = vga_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
  localparam int unsigned VTotal  = vga_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);
  localparam logic [11:0] HTotalW = 12'(HTotal);
  localparam logic [10:0] VTotalW = 11'(VTotal);
  localparam logic [10:0] HTimeout = 11'(2 * HTotal);
  localparam logic [10:0] HStartW = 11'(H_SYNC + H_BACK);
  localparam logic [10:0] HEndW   = 11'(H_SYNC + H_BACK + H_VISIBLE);
  localparam logic [9:0]  VStartW = 10'(V_SYNC + V_BACK);
  localparam logic [9:0]  VEndW   = 10'(V_SYNC + V_BACK + V_VISIBLE);
  localparam logic [7:0]  LockW   = 8'(LOCK_FRAMES);

  logic h_edge, v_edge;

  vga_sync_edge #(.ActiveLow(SYNC_ACTIVE_LOW)) u_hs_edge (
    .clk_i (pixel_clk),
    .rst_ni(reset_n),
    .sync_i(h_sync),
    .edge_o(h_edge)
  );

  vga_sync_edge #(.ActiveLow(SYNC_ACTIVE_LOW)) u_vs_edge (
    .clk_i (pixel_clk),
    .rst_ni(reset_n),
    .sync_i(v_sync),
    .edge_o(v_edge)
  );

  logic [2:0]  pix_q, pix_d;
  logic [10:0] hcount_q, hcount_d;
  logic [9:0]  vcount_q, vcount_d;
  logic        vs_pending_q, vs_pending_d;
  logic        line_err_q, line_err_d;
  logic [1:0]  state_q, state_d;
  logic [7:0]  good_cnt_q, good_cnt_d;
  logic        visible_q, visible_d;
  logic [9:0]  row_q, row_d, col_q, col_d;
  logic [2:0]  rgb_q, rgb_d;
  logic        line_start_q, frame_start_q;
  logic        boundary, line_bad, timeout, frame_bad;

  always_comb begin
    pix_d     = {R, G, B};
    boundary  = h_edge && (vs_pending_q || v_edge);
    line_bad  = h_edge && (({1'b0, hcount_q} + 12'd1) != HTotalW);
    timeout   = !h_edge && (hcount_q >= HTimeout);
    frame_bad = ({1'b0, vcount_q} + 11'd1) != VTotalW;

    hcount_d = h_edge ? 11'd0 : ((hcount_q == '1) ? hcount_q : hcount_q + 11'd1);
    vcount_d = vcount_q;
    if (boundary) begin
      vcount_d = 10'd0;
    end else if (h_edge && (vcount_q != '1)) begin
      vcount_d = vcount_q + 10'd1;
    end

    vs_pending_d = boundary ? 1'b0 : (vs_pending_q || v_edge);
    line_err_d   = boundary ? 1'b0 : (line_err_q || line_bad || timeout);

    state_d    = state_q;
    good_cnt_d = good_cnt_q;
    case (state_q)
      StSearch: begin
        if (boundary) begin
          state_d    = StMeasure;
          good_cnt_d = 8'd0;
        end
      end
      StMeasure: begin
        if (timeout) begin
          state_d    = StSearch;
          good_cnt_d = 8'd0;
        end else if (boundary) begin
          // The line closed by this edge still belongs to the frame being judged.
          if (line_err_q || line_bad || frame_bad) begin
            good_cnt_d = 8'd0;
          end else if ((good_cnt_q + 8'd1) >= LockW) begin
            state_d    = StLocked;
            good_cnt_d = 8'd0;
          end else begin
            good_cnt_d = good_cnt_q + 8'd1;
          end
        end
      end
      StLocked: begin
        if (line_bad || timeout || (boundary && frame_bad)) begin
          state_d    = StSearch;
          good_cnt_d = 8'd0;
        end
      end
      default: begin
        state_d    = StSearch;
        good_cnt_d = 8'd0;
      end
    endcase

    // Map with the next-state counters: they index the pixel now held in pix_q.
    visible_d = (state_q == StLocked) && (hcount_d >= HStartW) && (hcount_d < HEndW) &&
                (vcount_d >= VStartW) && (vcount_d < VEndW);
    col_d = visible_d ? 10'(hcount_d - HStartW) : 10'd0;
    row_d = visible_d ? (vcount_d - VStartW) : 10'd0;
    rgb_d = visible_d ? pix_q : 3'd0;
  end

  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      pix_q         <= 3'd0;
      hcount_q      <= 11'd0;
      vcount_q      <= 10'd0;
      vs_pending_q  <= 1'b0;
      line_err_q    <= 1'b0;
      state_q       <= StSearch;
      good_cnt_q    <= 8'd0;
      visible_q     <= 1'b0;
      row_q         <= 10'd0;
      col_q         <= 10'd0;
      rgb_q         <= 3'd0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      pix_q         <= pix_d;
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      vs_pending_q  <= vs_pending_d;
      line_err_q    <= line_err_d;
      state_q       <= state_d;
      good_cnt_q    <= good_cnt_d;
      visible_q     <= visible_d;
      row_q         <= row_d;
      col_q         <= col_d;
      rgb_q         <= rgb_d;
      line_start_q  <= h_edge;
      frame_start_q <= boundary;
    end
  end

  assign locked      = (state_q == StLocked);
  assign visible     = visible_q;
  assign row         = row_q;
  assign col         = col_q;
  assign rgb         = rgb_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Directed bench: a small-mode VGA stream drives an active-low and an active-high
// receiver side by side (the latter with inverted sync pins).
module tb_vga_sync_receiver;

  localparam int HVis = 32, HFront = 2, HSyncW = 6, HBack = 4;
  localparam int VVis = 12, VFront = 1, VSyncW = 2, VBack = 3;
  localparam int HT = HVis + HFront + HSyncW + HBack;  // 44
  localparam int VT = VVis + VFront + VSyncW + VBack;  // 18
  localparam int HS = HSyncW + HBack;                  // first visible pixel
  localparam int VS = VSyncW + VBack;                  // first visible line
  localparam int FrameCycles = HT * VT;

  logic pixel_clk = 1'b0;
  logic reset_n   = 1'b1;
  logic hs_lo = 1'b1, vs_lo = 1'b1, hs_hi = 1'b0, vs_hi = 1'b0;
  logic r_pin = 1'b0, g_pin = 1'b0, b_pin = 1'b0;

  logic       locked_lo, visible_lo, line_start_lo, frame_start_lo;
  logic       locked_hi, visible_hi, line_start_hi, frame_start_hi;
  logic [9:0] row_lo, col_lo, row_hi, col_hi;
  logic [2:0] rgb_lo, rgb_hi;

  always #5 pixel_clk = ~pixel_clk;

  vga_sync_receiver #(
    .H_VISIBLE(HVis), .H_FRONT(HFront), .H_SYNC(HSyncW), .H_BACK(HBack),
    .V_VISIBLE(VVis), .V_FRONT(VFront), .V_SYNC(VSyncW), .V_BACK(VBack),
    .SYNC_ACTIVE_LOW(1'b1), .LOCK_FRAMES(2)
  ) dut_lo (
    .pixel_clk(pixel_clk), .reset_n(reset_n), .h_sync(hs_lo), .v_sync(vs_lo),
    .R(r_pin), .G(g_pin), .B(b_pin), .locked(locked_lo), .visible(visible_lo),
    .row(row_lo), .col(col_lo), .rgb(rgb_lo), .line_start(line_start_lo),
    .frame_start(frame_start_lo)
  );

  vga_sync_receiver #(
    .H_VISIBLE(HVis), .H_FRONT(HFront), .H_SYNC(HSyncW), .H_BACK(HBack),
    .V_VISIBLE(VVis), .V_FRONT(VFront), .V_SYNC(VSyncW), .V_BACK(VBack),
    .SYNC_ACTIVE_LOW(1'b0), .LOCK_FRAMES(2)
  ) dut_hi (
    .pixel_clk(pixel_clk), .reset_n(reset_n), .h_sync(hs_hi), .v_sync(vs_hi),
    .R(r_pin), .G(g_pin), .B(b_pin), .locked(locked_hi), .visible(visible_hi),
    .row(row_hi), .col(col_hi), .rgb(rgb_hi), .line_start(line_start_hi),
    .frame_start(frame_start_hi)
  );

  int checks = 0, errors = 0;
  int hc = 0, vc = 0;
  int p0_hc = -1, p0_vc = -1, p1_hc = -1, p1_vc = -1, p2_hc = -1, p2_vc = -1;
  int fs_lo = 0, unl_lo = 0, unl_hi = 0, vis_lo = 0, vis_hi = 0;
  bit hold_hs = 1'b0, short_en = 1'b0;
  int short_vc = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_pair(input string tag, input int obs_lo, input int obs_hi, input int exp);
    chk({tag, "_lo"}, obs_lo, exp);
    chk({tag, "_hi"}, obs_hi, exp);
  endtask

  // One pixel clock: drive the next pin pixel; outputs now show the pixel in p2.
  task automatic step();
    bit act_h, act_v;
    int len;
    @(posedge pixel_clk);
    #1;
    p2_hc = p1_hc; p2_vc = p1_vc;
    p1_hc = p0_hc; p1_vc = p0_vc;
    p0_hc = hc;    p0_vc = vc;
    act_h = (hc < HSyncW) && !hold_hs;
    act_v = (vc < VSyncW);
    hs_lo = !act_h; hs_hi = act_h;
    vs_lo = !act_v; vs_hi = act_v;
    r_pin = (hc == HS) && (vc == VS);
    b_pin = (hc == HS + 1) && (vc == VS);
    g_pin = (hc == HS + HVis - 1) && (vc == VS + VVis - 1);
    len = (short_en && vc == short_vc) ? HT - 1 : HT;
    hc++;
    if (hc == len) begin
      hc = 0;
      if (short_en && vc == short_vc) short_en = 1'b0;
      vc = (vc == VT - 1) ? 0 : vc + 1;
    end
    if (frame_start_lo) fs_lo++;
    if (!locked_lo) unl_lo++;
    if (!locked_hi) unl_hi++;
    if (visible_lo) vis_lo++;
    if (visible_hi) vis_hi++;
  endtask

  task automatic run_until_pix(input string tag, input int thc, input int tvc);
    int n = 0;
    do begin
      step();
      n++;
    end while (!(p2_hc == thc && p2_vc == tvc) && n < 2 * FrameCycles);
    if (!(p2_hc == thc && p2_vc == tvc)) chk({tag, "_reach"}, 0, 1);
  endtask

  task automatic run_until_fs(input string tag, input int target);
    int n = 0;
    while (fs_lo < target && n < 10 * FrameCycles) begin
      step();
      n++;
    end
    if (fs_lo < target) chk({tag, "_reach"}, fs_lo, target);
  endtask

  task automatic chk_map(input string tag, input int vis, input int rw, input int cl,
                         input int px);
    chk_pair({tag, "_vis"}, visible_lo, visible_hi, vis);
    chk_pair({tag, "_row"}, row_lo, row_hi, rw);
    chk_pair({tag, "_col"}, col_lo, col_hi, cl);
    chk_pair({tag, "_rgb"}, rgb_lo, rgb_hi, px);
  endtask

  task automatic chk_all_zero(input string tag);
    chk_pair({tag, "_locked"}, locked_lo, locked_hi, 0);
    chk_pair({tag, "_ls"}, line_start_lo, line_start_hi, 0);
    chk_pair({tag, "_fs"}, frame_start_lo, frame_start_hi, 0);
    chk_map(tag, 0, 0, 0, 0);
  endtask

  initial begin
    int base, n;

    // Power-on reset
    #2 reset_n = 1'b0;
    #1 chk_all_zero("rst_async");
    repeat (3) @(posedge pixel_clk);
    #1 chk_all_zero("rst_hold");
    reset_n = 1'b1;

    // Clean stream from reset: lock on the 3rd frame_start
    run_until_fs("fs1", 1);
    chk("fs1_align_h", p2_hc, 0);
    chk("fs1_align_v", p2_vc, 0);
    chk_pair("fs1_locked", locked_lo, locked_hi, 0);
    run_until_fs("fs2", 2);
    chk_pair("fs2_locked", locked_lo, locked_hi, 0);
    chk_pair("fs2_fs", frame_start_lo, frame_start_hi, 1);
    run_until_pix("pre_lock", HT - 1, VT - 1);
    chk_pair("pre_lock", locked_lo, locked_hi, 0);
    step();
    chk_pair("lock_fs", frame_start_lo, frame_start_hi, 1);
    chk_pair("lock_rise", locked_lo, locked_hi, 1);
    unl_lo = 0; unl_hi = 0;
    run_until_fs("hold5", fs_lo + 5);
    chk_pair("lock_5frames_drops", unl_lo, unl_hi, 0);

    // Line start and pixel mapping while locked
    run_until_pix("ls", 0, 3);
    chk_pair("ls_pulse", line_start_lo, line_start_hi, 1);
    chk_pair("ls_no_fs", frame_start_lo, frame_start_hi, 0);
    step();
    chk_pair("ls_clear", line_start_lo, line_start_hi, 0);
    run_until_pix("map_pre", HS - 1, VS);
    chk_map("map_pre", 0, 0, 0, 0);
    step();
    chk_map("map_first", 1, 0, 0, 4);
    step();
    chk_map("map_second", 1, 0, 1, 1);
    run_until_pix("map_last", HS + HVis - 1, VS + VVis - 1);
    chk_map("map_last", 1, VVis - 1, HVis - 1, 2);
    step();
    chk_map("map_after", 0, 0, 0, 0);

    // One short line mid-frame
    run_until_pix("short_arm", 0, 2);
    short_vc = 8;
    short_en = 1'b1;
    run_until_pix("short_end", HT - 2, 8);
    chk_pair("short_pre", locked_lo, locked_hi, 1);
    step();
    chk_pair("short_drop", locked_lo, locked_hi, 0);
    chk_pair("short_ls", line_start_lo, line_start_hi, 1);
    vis_lo = 0; vis_hi = 0;
    run_until_fs("relock_a", fs_lo + 1);
    chk_pair("short_vis_after", vis_lo, vis_hi, 0);
    chk_pair("relock_a", locked_lo, locked_hi, 0);
    run_until_fs("relock_b", fs_lo + 1);
    chk_pair("relock_b", locked_lo, locked_hi, 0);
    run_until_fs("relock_c", fs_lo + 1);
    chk_pair("relock_c", locked_lo, locked_hi, 1);

    // Missing hsync: timeout to SEARCH, hcount saturates
    run_until_pix("hold_start", 20, 6);
    hold_hs = 1'b1;
    repeat (40) step();
    chk_pair("hold_early", locked_lo, locked_hi, 1);
    repeat (60) step();
    chk_pair("hold_timeout", locked_lo, locked_hi, 0);
    repeat (2100) step();
    chk_pair("hold_sat", dut_lo.hcount_q, dut_hi.hcount_q, 2047);
    chk_pair("hold_vis", visible_lo, visible_hi, 0);
    hold_hs = 1'b0;
    n = 0;
    while (!(locked_lo && locked_hi) && n < 8 * FrameCycles) begin
      step();
      n++;
    end
    chk_pair("hold_relock", locked_lo, locked_hi, 1);

    // Asynchronous reset mid-line while a visible pixel is showing
    run_until_pix("mid_rst", HS + 5, VS + 3);
    chk_map("mid_pre", 1, 3, 5, 0);
    #2 reset_n = 1'b0;
    #1 chk_all_zero("mid_rst");
    step();
    step();
    reset_n = 1'b1;
    base = fs_lo;
    run_until_fs("rst_relock_a", base + 1);
    chk_pair("rst_relock_a", locked_lo, locked_hi, 0);
    run_until_fs("rst_relock_b", base + 2);
    chk_pair("rst_relock_b", locked_lo, locked_hi, 0);
    run_until_fs("rst_relock_c", base + 3);
    chk_pair("rst_relock_c", locked_lo, locked_hi, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_sync_receiver.md
Name: vga_sync_receiver

Overview:
- Receiving end of the VGA link that vga_controller drives: samples h_sync/v_sync/R/G/B on the pixel clock and recovers line/frame timing.
- Validates timing against the configured mode and produces row/col/visible plus registered RGB, so a captured stream can be checked or re-processed in-fabric.
- Sits beside vga_controller in loopback test tops, or downstream of an external VGA source.

Parameters:
- H_VISIBLE, 640, active pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, active lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- SYNC_ACTIVE_LOW, 1, 1 = sync pulses are low, 0 = sync pulses are high
- LOCK_FRAMES, 2, consecutive good frames required to lock

Ports:
- pixel_clk  in  1  pixel clock; all inputs are synchronous to it
- reset_n  in  1  asynchronous, active-low reset
- h_sync  in  1  received horizontal sync
- v_sync  in  1  received vertical sync
- R, G, B  in  1 each  received colour bits
- locked  out  1  timing validated
- visible  out  1  current output pixel is in the active area and locked = 1
- row  out  10  active line index, 0..V_VISIBLE-1
- col  out  10  active pixel index, 0..H_VISIBLE-1
- rgb  out  3  {R,G,B} aligned with row/col; forced to 0 when visible = 0
- line_start  out  1  one-cycle pulse on each hsync leading edge
- frame_start  out  1  one-cycle pulse on each frame boundary

Behaviour:
- Derived constants: H_TOTAL = sum of the H parameters (800); V_TOTAL = sum of the V parameters (525).
- Reset: asynchronous. All outputs go to 0, the FSM enters SEARCH, and all counters clear. Reset asserted mid-frame behaves identically.
- Input stage: every input is registered once. A leading edge is "registered sync active now, inactive on the previous cycle", with polarity set by SYNC_ACTIVE_LOW.
- hcount (11 bits):
  - Cleared to 0 in the cycle that the hsync leading edge is detected; otherwise increments by 1.
  - Saturates at 2047.
  - Measured line length = hcount + 1, sampled at the next edge.
- vcount (10 bits):
  - A vsync leading edge sets vs_pending.
  - The first hsync edge with vs_pending (or in the same cycle) is the frame boundary: vcount clears to 0, frame_start pulses, and vs_pending clears.
  - Other hsync edges increment vcount, saturating at 1023.
  - Measured frame length = vcount + 1, sampled at the boundary.
- Line check: a line length that is not H_TOTAL sets line_err for the current frame.
- Timeout: hcount reaching 2*H_TOTAL with no edge counts as a line error.
- FSM:
  - SEARCH → MEASURE at the first frame boundary; good_cnt = 0.
  - MEASURE, at each boundary: if line_err = 0 and the frame length is V_TOTAL, good_cnt increments. When good_cnt reaches LOCK_FRAMES, go to LOCKED; otherwise stay. A bad frame clears good_cnt and stays in MEASURE.
  - Timeout in MEASURE → SEARCH.
  - LOCKED: any line error or bad frame length → SEARCH on the next cycle; locked drops in that same cycle.
  - line_err clears at each boundary.
- locked = 1 only in LOCKED.
- Mapping:
  - visible = locked && H_SYNC+H_BACK ≤ hcount < H_SYNC+H_BACK+H_VISIBLE && V_SYNC+V_BACK ≤ vcount < V_SYNC+V_BACK+V_VISIBLE.
  - col = hcount − (H_SYNC+H_BACK) and row = vcount − (V_SYNC+V_BACK), truncated to 10 bits; both are 0 when visible = 0.
- Latency:
  - Pin → line_start/frame_start: 2 cycles.
  - Pin → rgb/row/col/visible: 2 cycles, all registered outputs.
  - A pixel driven at the pin in cycle t appears on rgb in cycle t+2, with matching row/col.
- Simultaneous vsync and hsync edges form the boundary on that same edge.
- Sync pulses are not width-checked.

Decomposition:
- Package vga_timing_pkg holds the 640x480@60 constants and the H_TOTAL/V_TOTAL computation, shared with vga_controller.
- Sub-module vga_sync_edge: one input register plus a polarity-aware leading-edge detector. It is instantiated for h_sync and for v_sync.

Test Plan:
- Clean 800x525 stream from vga_controller, from reset → locked rises 1 cycle after the frame boundary that completes the 2nd good frame (3rd frame_start) and stays high across 5 frames.
- Locked; drive R = 1 only at pin hcount 144, line 35 → rgb = 3'b100 with row = 0, col = 0, visible = 1 exactly 2 cycles later; pin hcount 143 yields visible = 0.
- Locked; one line of 799 pixels mid-frame → locked falls at that edge, visible stays 0 afterwards, relock after 2 further clean frames.
- Hsync held inactive for 1600 cycles while locked → FSM enters SEARCH, locked = 0, hcount saturates without wrapping.
- reset_n pulsed low mid-line → all outputs 0 immediately, not waiting for a clock edge; normal relock sequence follows.
- SYNC_ACTIVE_LOW = 0 with inverted sync inputs → identical lock timing and pixel mapping to the first scenario.
